// File: rtl/mixcolumns_shiftrows_generic.sv
// AES linear layer: ShiftRows+MixColumns (forward) or InvMixColumns+InvShiftRows
// (inverse), column-serial under an IDLE/CALC/DONE handshake FSM.
module mixcolumns_shiftrows_generic #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mode,
    input  logic         skip_mix,
    input  logic [127:0] state,
    input  logic         i_valid,
    output logic         i_ready,
    output logic [127:0] state_out,
    output logic         o_valid,
    input  logic         o_ready
);

    generate
        if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cfg
            $error("COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    localparam logic [2:0] STEP = 3'(COLS_PER_CYCLE);

    typedef enum logic [1:0] {IDLE, CALC, DONE} fsm_t;

    fsm_t         fsm_q, fsm_d;
    logic [2:0]   cnt_q, cnt_d;
    logic [127:0] work_q, work_d;
    logic [127:0] out_q, out_d;
    logic         mode_q, mode_d;
    logic         skip_q, skip_d;
    logic         ov_q, ov_d;
    logic [1:0]   idx;
    logic [31:0]  col;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 4; i++) begin
            if (k[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Circulant coefficients packed as nibbles: {02 03 01 01} or {0e 0b 0d 09}
    function automatic logic [31:0] mix_col(input logic [31:0] c, input logic inv);
        logic [15:0] cf;
        logic [31:0] res;
        cf  = inv ? 16'hebd9 : 16'h2311;
        res = '0;
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 4; j++) begin
                res[31-8*r -: 8] = res[31-8*r -: 8]
                                 ^ gmul(c[31-8*j -: 8], cf[15-4*((j-r+4)%4) -: 4]);
            end
        end
        return res;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        int src;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                src = inv ? (c - r + 4) % 4 : (c + r) % 4;
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*src+r) -: 8];
            end
        end
        return o;
    endfunction

    always_comb begin
        fsm_d  = fsm_q;
        cnt_d  = cnt_q;
        work_d = work_q;
        out_d  = out_q;
        mode_d = mode_q;
        skip_d = skip_q;
        ov_d   = ov_q;
        idx    = '0;
        col    = '0;
        unique case (fsm_q)
            IDLE: begin
                if (i_valid) begin
                    mode_d = mode;
                    skip_d = skip_mix;
                    cnt_d  = '0;
                    work_d = mode ? state : shift_rows(state, 1'b0);
                    fsm_d  = CALC;
                end
            end
            CALC: begin
                for (int k = 0; k < COLS_PER_CYCLE; k++) begin
                    idx = cnt_q[1:0] + 2'(k);
                    col = work_q[127-32*idx -: 32];
                    work_d[127-32*idx -: 32] = skip_q ? col : mix_col(col, mode_q);
                end
                cnt_d = cnt_q + STEP;
                if (cnt_q + STEP == 3'd4) begin
                    out_d = mode_q ? shift_rows(work_d, 1'b1) : work_d;
                    ov_d  = 1'b1;
                    cnt_d = '0;
                    fsm_d = DONE;
                end
            end
            DONE: begin
                if (o_ready) begin
                    ov_d  = 1'b0;
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q  <= IDLE;
            cnt_q  <= '0;
            work_q <= '0;
            out_q  <= '0;
            mode_q <= 1'b0;
            skip_q <= 1'b0;
            ov_q   <= 1'b0;
        end else begin
            fsm_q  <= fsm_d;
            cnt_q  <= cnt_d;
            work_q <= work_d;
            out_q  <= out_d;
            mode_q <= mode_d;
            skip_q <= skip_d;
            ov_q   <= ov_d;
        end
    end

    assign i_ready   = (fsm_q == IDLE);
    assign state_out = out_q;
    assign o_valid   = ov_q;

endmodule

// File: tb/tb_mixcolumns_shiftrows_generic.sv
// Bench for mixcolumns_shiftrows_generic: three instances (1, 2, 4 columns/cycle)
// checked every cycle against a matrix-level AES model plus FIPS-197 literals.
module tb_mixcolumns_shiftrows_generic;

    localparam logic [127:0] FIPS_IN  = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] FIPS_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;
    localparam logic [127:0] FIPS_SKP = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] DB_IN    = 128'hdb135345db135345db135345db135345;
    localparam logic [127:0] DB_OUT   = 128'h8e4da1bc8e4da1bc8e4da1bc8e4da1bc;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [2:0]   md, sk, iv, ir, ov, ordy;
    logic [383:0] stf, sof;
    bit           chk_en = 1'b0;
    int           nvec = 0;
    int           nerr = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mixcolumns_shiftrows_generic #(.COLS_PER_CYCLE(1 << g)) u_dut (
            .clk      (clk),
            .rst      (rst),
            .mode     (md[g]),
            .skip_mix (sk[g]),
            .state    (stf[128*g +: 128]),
            .i_valid  (iv[g]),
            .i_ready  (ir[g]),
            .state_out(sof[128*g +: 128]),
            .o_valid  (ov[g]),
            .o_ready  (ordy[g])
        );
    end

    function automatic logic [7:0] gf(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (16'h11b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [127:0] aes_lin(input bit inv, input bit skip, input logic [127:0] s);
        logic [7:0] m[4][4];
        logic [7:0] t[4][4];
        logic [7:0] u[4][4];
        logic [7:0] base[4];
        logic [127:0] o;
        if (inv) base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     base = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                m[r][c] = s[127-8*(4*c+r) -: 8];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                t[r][c] = inv ? m[r][c] : m[r][(c+r)%4];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                u[r][c] = '0;
                for (int k = 0; k < 4; k++)
                    u[r][c] = u[r][c] ^ gf(base[(k-r+4)%4], t[k][c]);
                if (skip) u[r][c] = t[r][c];
            end
        o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127-8*(4*c+r) -: 8] = inv ? u[r][(c-r+4)%4] : u[r][c];
        return o;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    int           ph[3]   = '{0, 0, 0};
    int           left[3] = '{0, 0, 0};
    logic [127:0] mres[3] = '{'0, '0, '0};
    logic [127:0] mout[3] = '{'0, '0, '0};
    bit           mval[3] = '{0, 0, 0};

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                ph[i] = 0;
                mout[i] = '0;
                mval[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                case (ph[i])
                    0: if (iv[i]) begin
                        mres[i] = aes_lin(md[i], sk[i], stf[128*i +: 128]);
                        left[i] = 4 >> i;
                        ph[i] = 1;
                    end
                    1: begin
                        left[i] = left[i] - 1;
                        if (left[i] == 0) begin
                            mout[i] = mres[i];
                            mval[i] = 1'b1;
                            ph[i] = 2;
                        end
                    end
                    default: if (ordy[i]) begin
                        mval[i] = 1'b0;
                        ph[i] = 0;
                    end
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("i_ready[%0d]", i), 128'(ir[i]), 128'(ph[i] == 0));
                chk($sformatf("o_valid[%0d]", i), 128'(ov[i]), 128'(mval[i]));
                chk($sformatf("state_out[%0d]", i), sof[128*i +: 128], mout[i]);
            end
        end
    end

    task automatic start_block(input int i, input bit m, input bit s, input logic [127:0] x);
        @(negedge clk);
        md[i] = m;
        sk[i] = s;
        stf[128*i +: 128] = x;
        iv[i] = 1'b1;
        @(posedge clk);
        #1 iv[i] = 1'b0;
    endtask

    task automatic run_block(input int i, input bit m, input bit s,
                             input logic [127:0] x, input logic [127:0] exp);
        int lat;
        start_block(i, m, s, x);
        lat = 0;
        while (!ov[i] && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        chk($sformatf("latency[%0d]", i), 128'(lat), 128'(4 >> i));
        chk($sformatf("result[%0d]", i), sof[128*i +: 128], exp);
        if (ordy[i]) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [127:0] held;
        md = '0; sk = '0; iv = '0; ordy = '1; stf = '0;
        chk("model_fwd", aes_lin(1'b0, 1'b0, FIPS_IN), FIPS_OUT);
        chk("model_skip", aes_lin(1'b0, 1'b1, FIPS_IN), FIPS_SKP);
        chk("model_inv", aes_lin(1'b1, 1'b0, FIPS_OUT), FIPS_IN);
        chk("model_db", aes_lin(1'b0, 1'b0, DB_IN), DB_OUT);
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_iready", 128'(ir[i]), 128'(1));
            chk("rst_ovalid", 128'(ov[i]), 128'(0));
            chk("rst_out", sof[128*i +: 128], 128'h0);
        end

        for (int i = 0; i < 3; i++) begin
            run_block(i, 1'b0, 1'b0, FIPS_IN, FIPS_OUT);
            run_block(i, 1'b0, 1'b1, FIPS_IN, FIPS_SKP);
            run_block(i, 1'b1, 1'b0, FIPS_OUT, FIPS_IN);
            run_block(i, 1'b1, 1'b1, FIPS_OUT, aes_lin(1'b1, 1'b1, FIPS_OUT));
            run_block(i, 1'b0, 1'b0, DB_IN, DB_OUT);
            run_block(i, 1'b1, 1'b0, DB_OUT, DB_IN);
        end

        ordy[0] = 1'b0;
        run_block(0, 1'b0, 1'b0, FIPS_IN, FIPS_OUT);
        held = sof[127:0];
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 3) begin
                stf[127:0] = DB_IN;
                md[0] = 1'b1;
                iv[0] = 1'b1;
            end
            if (c == 5) iv[0] = 1'b0;
            @(posedge clk);
            #1;
            chk("bp_iready", 128'(ir[0]), 128'(0));
            chk("bp_ovalid", 128'(ov[0]), 128'(1));
            chk("bp_hold", sof[127:0], held);
        end
        @(negedge clk);
        ordy[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_ovalid", 128'(ov[0]), 128'(0));
        chk("bp_release_iready", 128'(ir[0]), 128'(1));
        chk("bp_release_out", sof[127:0], FIPS_OUT);

        start_block(0, 1'b0, 1'b0, DB_IN);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_iready", 128'(ir[0]), 128'(1));
        chk("arst_ovalid", 128'(ov[0]), 128'(0));
        chk("arst_out", sof[127:0], 128'h0);
        @(negedge clk);
        rst = 1'b0;
        run_block(0, 1'b0, 1'b0, FIPS_IN, FIPS_OUT);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
